// File: rtl/cl_nvdla_axil2csb.sv
// AXI-Lite slave to NVDLA CSB bridge: one transaction in flight, window decode,
// round-robin write/read arbitration and an optional CSB response timeout.
module cl_nvdla_axil2csb #(
    parameter int unsigned       ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter bit                POSTED_WR = 1'b1,
    parameter int unsigned       TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic              csb2nvdla_valid,
    input  logic              csb2nvdla_ready,
    output logic [15:0]       csb2nvdla_addr,
    output logic [31:0]       csb2nvdla_wdat,
    output logic              csb2nvdla_write,
    output logic              csb2nvdla_nposted,
    input  logic              nvdla2csb_valid,
    input  logic [31:0]       nvdla2csb_data,
    input  logic              nvdla2csb_wr_complete
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, CSB_REQ, CSB_WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic             run_q, run_d;
    logic             is_wr_q, is_wr_d;
    logic             prio_wr_q, prio_wr_d;
    logic [15:0]      addr_q, addr_d;
    logic [31:0]      wdat_q, wdat_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       resp_q, resp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic              wr_elig, rd_elig, grant_wr, grant_rd;
    logic [ADDR_W-1:0] req_addr, offset;
    logic              out_win, bad_req, timeout_hit;

    // run_q keeps every ready low until the first edge after reset release
    assign run_d       = 1'b1;
    assign wr_elig     = run_q && (state_q == IDLE) && s_awvalid && s_wvalid;
    assign rd_elig     = run_q && (state_q == IDLE) && s_arvalid;
    assign grant_wr    = wr_elig && (!rd_elig || prio_wr_q);
    assign grant_rd    = rd_elig && !grant_wr;
    assign req_addr    = grant_wr ? s_awaddr : s_araddr;
    assign offset      = req_addr - BASE_ADDR;
    assign out_win     = (req_addr < BASE_ADDR) || ((offset >> 18) != '0);
    assign bad_req     = (offset[1:0] != 2'b00) || (grant_wr && (s_wstrb != 4'hF));
    assign timeout_hit = (TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT - 1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            run_q     <= 1'b0;
            is_wr_q   <= 1'b0;
            prio_wr_q <= 1'b1;
            addr_q    <= '0;
            wdat_q    <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            is_wr_q   <= is_wr_d;
            prio_wr_q <= prio_wr_d;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        prio_wr_d = prio_wr_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_wr || grant_rd) begin
                    is_wr_d = grant_wr;
                    rdata_d = '0;
                    // priority only rotates when both sides actually contended
                    if (wr_elig && rd_elig) prio_wr_d = !grant_wr;
                    if (out_win) begin
                        state_d = RESP;
                        resp_d  = RESP_DECERR;
                    end else if (bad_req) begin
                        state_d = RESP;
                        resp_d  = RESP_SLVERR;
                    end else begin
                        state_d = CSB_REQ;
                        resp_d  = RESP_OKAY;
                        addr_d  = offset[17:2];
                        wdat_d  = grant_wr ? s_wdata : '0;
                    end
                end
            end
            CSB_REQ: begin
                if (csb2nvdla_ready) begin
                    cnt_d   = '0;
                    state_d = (is_wr_q && POSTED_WR) ? RESP : CSB_WAIT;
                end
            end
            CSB_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!is_wr_q && nvdla2csb_valid) begin
                    rdata_d = nvdla2csb_data;
                    state_d = RESP;
                end else if (is_wr_q && nvdla2csb_wr_complete) begin
                    state_d = RESP;
                end else if (timeout_hit) begin
                    resp_d  = RESP_SLVERR;
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if ((is_wr_q && s_bready) || (!is_wr_q && s_rready)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_awready       = grant_wr;
        s_wready        = grant_wr;
        s_arready       = grant_rd;
        csb2nvdla_valid = (state_q == CSB_REQ);
        s_bvalid        = (state_q == RESP) && is_wr_q;
        s_rvalid        = (state_q == RESP) && !is_wr_q;
    end

    assign s_bresp           = resp_q;
    assign s_rresp           = resp_q;
    assign s_rdata           = rdata_q;
    assign csb2nvdla_addr    = addr_q;
    assign csb2nvdla_wdat    = wdat_q;
    assign csb2nvdla_write   = is_wr_q;
    assign csb2nvdla_nposted = is_wr_q & ~POSTED_WR;

endmodule

// File: tb/tb_cl_nvdla_axil2csb.sv
// Bench for cl_nvdla_axil2csb: dut 0 is posted with a 0x1000_0000 window and
// TIMEOUT=16, dut 1 is non-posted at base 0 with the timeout disabled.
module tb_cl_nvdla_axil2csb;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] awaddr, wdata, araddr, nv_data;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        csb_ready, nv_valid, nv_wrc;

    logic [1:0]  awready, wready, bvalid, arready, rvalid, csb_valid, csb_write, csb_np;
    logic [1:0]  bresp [2];
    logic [1:0]  rresp [2];
    logic [31:0] rdata [2];
    logic [15:0] csb_addr [2];
    logic [31:0] csb_wdat [2];

    int errors = 0;
    int checks = 0;

    int acc_cnt [2] = '{0, 0};
    int csb_cnt [2] = '{0, 0};
    int b_cnt   [2] = '{0, 0};
    int r_cnt   [2] = '{0, 0};
    logic [15:0] seen_addr  [2];
    logic [31:0] seen_wdat  [2];
    logic        seen_wr    [2];
    logic        seen_np    [2];
    logic [1:0]  seen_bresp [2];
    logic [1:0]  seen_rresp [2];
    logic [31:0] seen_rdata [2];

    always #5 clk = ~clk;

    cl_nvdla_axil2csb #(.ADDR_W(32), .BASE_ADDR(32'h1000_0000), .POSTED_WR(1'b1), .TIMEOUT(16)) dut0 (
        .clk(clk), .rstn(rstn),
        .s_awaddr(awaddr), .s_awvalid(awvalid), .s_awready(awready[0]),
        .s_wdata(wdata), .s_wstrb(wstrb), .s_wvalid(wvalid), .s_wready(wready[0]),
        .s_bresp(bresp[0]), .s_bvalid(bvalid[0]), .s_bready(bready),
        .s_araddr(araddr), .s_arvalid(arvalid), .s_arready(arready[0]),
        .s_rdata(rdata[0]), .s_rresp(rresp[0]), .s_rvalid(rvalid[0]), .s_rready(rready),
        .csb2nvdla_valid(csb_valid[0]), .csb2nvdla_ready(csb_ready),
        .csb2nvdla_addr(csb_addr[0]), .csb2nvdla_wdat(csb_wdat[0]),
        .csb2nvdla_write(csb_write[0]), .csb2nvdla_nposted(csb_np[0]),
        .nvdla2csb_valid(nv_valid), .nvdla2csb_data(nv_data), .nvdla2csb_wr_complete(nv_wrc)
    );

    cl_nvdla_axil2csb #(.ADDR_W(32), .BASE_ADDR(32'h0), .POSTED_WR(1'b0), .TIMEOUT(0)) dut1 (
        .clk(clk), .rstn(rstn),
        .s_awaddr(awaddr), .s_awvalid(awvalid), .s_awready(awready[1]),
        .s_wdata(wdata), .s_wstrb(wstrb), .s_wvalid(wvalid), .s_wready(wready[1]),
        .s_bresp(bresp[1]), .s_bvalid(bvalid[1]), .s_bready(bready),
        .s_araddr(araddr), .s_arvalid(arvalid), .s_arready(arready[1]),
        .s_rdata(rdata[1]), .s_rresp(rresp[1]), .s_rvalid(rvalid[1]), .s_rready(rready),
        .csb2nvdla_valid(csb_valid[1]), .csb2nvdla_ready(csb_ready),
        .csb2nvdla_addr(csb_addr[1]), .csb2nvdla_wdat(csb_wdat[1]),
        .csb2nvdla_write(csb_write[1]), .csb2nvdla_nposted(csb_np[1]),
        .nvdla2csb_valid(nv_valid), .nvdla2csb_data(nv_data), .nvdla2csb_wr_complete(nv_wrc)
    );

    // Inputs change 1 time unit after posedge, so negedge sees what the next edge samples
    always @(negedge clk) begin
        if (rstn) begin
            for (int d = 0; d < 2; d++) begin
                if (awvalid && wvalid && awready[d] && wready[d]) acc_cnt[d]++;
                if (arvalid && arready[d]) acc_cnt[d]++;
                if (csb_valid[d] && csb_ready) begin
                    csb_cnt[d]++;
                    seen_addr[d] = csb_addr[d];
                    seen_wdat[d] = csb_wdat[d];
                    seen_wr[d]   = csb_write[d];
                    seen_np[d]   = csb_np[d];
                end
                if (bvalid[d] && bready) begin
                    b_cnt[d]++;
                    seen_bresp[d] = bresp[d];
                end
                if (rvalid[d] && rready) begin
                    r_cnt[d]++;
                    seen_rresp[d] = rresp[d];
                    seen_rdata[d] = rdata[d];
                end
            end
        end
    end

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rsp;
        bit          csb;
        logic [15:0] caddr;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int get_cnt(input int which, input int d);
        case (which)
            0:       return acc_cnt[d];
            1:       return csb_cnt[d];
            2:       return b_cnt[d];
            default: return r_cnt[d];
        endcase
    endfunction

    task automatic wait_cnt(input int which, input int d, input int old, input string nm);
        int k = 0;
        while (get_cnt(which, d) == old && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        chk(nm, 32'(get_cnt(which, d) != old), 32'd1);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 1'b0;
        cycles(2);
        rstn = 1'b1;
        cycles(2);
    endtask

    task automatic run_vec(input vec_t v, input int i);
        int c0 = csb_cnt[0];
        int b0 = b_cnt[0];
        int r0 = r_cnt[0];
        int a0 = acc_cnt[0];
        @(posedge clk); #1;
        if (v.wr) begin
            awaddr = v.addr; wdata = v.wdata; wstrb = v.strb;
            awvalid = 1'b1; wvalid = 1'b1;
        end else begin
            araddr = v.addr; arvalid = 1'b1;
        end
        wait_cnt(0, 0, a0, $sformatf("v%0d_accept", i));
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        if (v.csb) begin
            wait_cnt(1, 0, c0, $sformatf("v%0d_csb_req", i));
            if (!v.wr) begin
                cycles(2);
                nv_data = v.rsp; nv_valid = 1'b1;
                cycles(1);
                nv_valid = 1'b0;
            end
        end
        wait_cnt(v.wr ? 2 : 3, 0, v.wr ? b0 : r0, $sformatf("v%0d_resp_seen", i));
        chk($sformatf("v%0d_csb_count", i), 32'(csb_cnt[0] - c0), 32'(v.csb));
        if (v.csb) begin
            chk($sformatf("v%0d_csb_addr", i), 32'(seen_addr[0]), 32'(v.caddr));
            chk($sformatf("v%0d_csb_write", i), 32'(seen_wr[0]), 32'(v.wr));
            chk($sformatf("v%0d_csb_nposted", i), 32'(seen_np[0]), 32'd0);
            if (v.wr) chk($sformatf("v%0d_csb_wdat", i), seen_wdat[0], v.wdata);
        end
        if (v.wr) begin
            chk($sformatf("v%0d_bresp", i), 32'(seen_bresp[0]), 32'(v.resp));
        end else begin
            chk($sformatf("v%0d_rresp", i), 32'(seen_rresp[0]), 32'(v.resp));
            chk($sformatf("v%0d_rdata", i), seen_rdata[0], v.rdata);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int n, r0, b0, c0, a0, seen;

        vt[0] = '{1'b1, 32'h1000_5004, 32'hA5A5_0001, 4'hF, 32'h0,         1'b1, 16'h1401, 2'b00, 32'h0};
        vt[1] = '{1'b0, 32'h1000_0008, 32'h0,         4'h0, 32'h1234_5678, 1'b1, 16'h0002, 2'b00, 32'h1234_5678};
        vt[2] = '{1'b0, 32'h0FFF_FFFC, 32'h0,         4'h0, 32'h0,         1'b0, 16'h0,    2'b11, 32'h0};
        vt[3] = '{1'b1, 32'h1000_0010, 32'h5555_AAAA, 4'h3, 32'h0,         1'b0, 16'h0,    2'b10, 32'h0};
        vt[4] = '{1'b0, 32'h1004_0000, 32'h0,         4'h0, 32'h0,         1'b0, 16'h0,    2'b11, 32'h0};
        vt[5] = '{1'b0, 32'h1003_FFFC, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b1, 16'hFFFF, 2'b00, 32'hDEAD_BEEF};
        vt[6] = '{1'b0, 32'h1000_0002, 32'h0,         4'h0, 32'h0,         1'b0, 16'h0,    2'b10, 32'h0};
        vt[7] = '{1'b1, 32'h1000_0000, 32'h0000_0000, 4'hF, 32'h0,         1'b1, 16'h0000, 2'b00, 32'h0};
        vt[8] = '{1'b1, 32'h1000_0001, 32'h0000_0007, 4'hF, 32'h0,         1'b0, 16'h0,    2'b10, 32'h0};
        vt[9] = '{1'b1, 32'h0000_0000, 32'h0000_0009, 4'h3, 32'h0,         1'b0, 16'h0,    2'b11, 32'h0};

        rstn = 1'b0;
        awaddr = 32'h1000_0004; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; araddr = 32'h1000_0004;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        bready = 1'b1; rready = 1'b1; csb_ready = 1'b1;
        nv_valid = 1'b0; nv_wrc = 1'b0; nv_data = 32'h0;

        // Requests pending during reset must see no ready and no response
        cycles(3);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_csb_valid", 32'(csb_valid), 32'd0);
        chk("rst_bvalid_rvalid", 32'({bvalid, rvalid}), 32'd0);
        chk("rst_rdata", rdata[0], 32'd0);
        chk("rst_resp", 32'({bresp[0], rresp[0]}), 32'd0);
        chk("rst_csb_fields", 32'({csb_addr[0], csb_write[0], csb_np[0]}), 32'd0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        rstn = 1'b1;
        cycles(2);

        for (int i = 0; i < 10; i++) run_vec(vt[i], i);

        // Posted write latency: accept at cycle 0, CSB valid at 1, bvalid at 2
        @(posedge clk); #1;
        awaddr = 32'h1000_0030; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        #1;
        chk("lat_c0_awready", 32'({awready[0], wready[0]}), 32'd3);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("lat_c1_csb_valid", 32'(csb_valid[0]), 32'd1);
        chk("lat_c1_bvalid", 32'(bvalid[0]), 32'd0);
        chk("lat_c1_csb_addr", 32'(csb_addr[0]), 32'h000C);
        @(posedge clk); #1;
        chk("lat_c2_bvalid", 32'(bvalid[0]), 32'd1);
        chk("lat_c2_csb_valid", 32'(csb_valid[0]), 32'd0);
        cycles(1);

        // Timeout: no CSB response, SLVERR with zero data 17 edges after accept
        a0 = acc_cnt[0]; r0 = r_cnt[0];
        @(posedge clk); #1;
        rready = 1'b0; araddr = 32'h1000_0100; arvalid = 1'b1;
        wait_cnt(0, 0, a0, "to_accept");
        arvalid = 1'b0;
        n = 0;
        while (!rvalid[0] && n < 40) begin @(posedge clk); #1; n++; end
        chk("to_edges_to_rvalid", 32'(n), 32'd17);
        chk("to_rresp", 32'(rresp[0]), 32'h2);
        chk("to_rdata", rdata[0], 32'h0);
        rready = 1'b1;
        cycles(1);
        cycles(2);
        nv_data = 32'h5A5A_5A5A; nv_valid = 1'b1;
        cycles(1);
        nv_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (rvalid[0] || csb_valid[0]) seen = 1;
            cycles(1);
        end
        chk("to_late_rsp_ignored", 32'(seen), 32'd0);
        chk("to_single_response", 32'(r_cnt[0] - r0), 32'd1);
        run_vec(vt[1], 10);

        // Tie twice in a row: write first after reset, then read
        do_reset();
        b0 = b_cnt[0]; r0 = r_cnt[0]; c0 = csb_cnt[0];
        @(posedge clk); #1;
        awaddr = 32'h1000_0020; wdata = 32'h0000_0077; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h1000_0024; arvalid = 1'b1;
        #1;
        chk("tie1_awready", 32'(awready[0]), 32'd1);
        chk("tie1_arready", 32'(arready[0]), 32'd0);
        wait_cnt(2, 0, b0, "tie1_bresp_seen");
        chk("tie1_csb_write", 32'({seen_wr[0], seen_addr[0]}), 32'h1_0008);
        chk("tie2_arready", 32'(arready[0]), 32'd1);
        chk("tie2_awready", 32'(awready[0]), 32'd0);
        c0 = csb_cnt[0];
        cycles(1);
        arvalid = 1'b0;
        b0 = b_cnt[0];
        wait_cnt(1, 0, c0, "tie2_csb_req");
        chk("tie2_csb_read", 32'({seen_wr[0], seen_addr[0]}), 32'h0_0009);
        cycles(2);
        nv_data = 32'hCAFE_0001; nv_valid = 1'b1;
        cycles(1);
        nv_valid = 1'b0;
        wait_cnt(3, 0, r0, "tie2_rresp_seen");
        chk("tie2_rdata", seen_rdata[0], 32'hCAFE_0001);
        chk("tie2_rresp", 32'(seen_rresp[0]), 32'h0);
        wait_cnt(2, 0, b0, "tie3_write_after_read");
        awvalid = 1'b0; wvalid = 1'b0;

        // Non-posted write on dut 1: bvalid only after wr_complete
        do_reset();
        a0 = acc_cnt[1]; c0 = csb_cnt[1]; b0 = b_cnt[1];
        @(posedge clk); #1;
        awaddr = 32'h0000_0040; wdata = 32'h0000_0011; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        wait_cnt(0, 1, a0, "np_accept");
        awvalid = 1'b0; wvalid = 1'b0;
        wait_cnt(1, 1, c0, "np_csb_req");
        chk("np_nposted", 32'(seen_np[1]), 32'd1);
        chk("np_csb_addr_wdat", {seen_addr[1], seen_wdat[1][15:0]}, 32'h0010_0011);
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            if (bvalid[1]) seen = 1;
            cycles(1);
        end
        chk("np_no_bvalid_before_complete", 32'(seen), 32'd0);
        nv_wrc = 1'b1;
        cycles(1);
        nv_wrc = 1'b0;
        wait_cnt(2, 1, b0, "np_bresp_seen");
        chk("np_bresp", 32'(seen_bresp[1]), 32'h0);

        // Valid held while CSB not ready, then dropped by asynchronous reset
        csb_ready = 1'b0;
        a0 = acc_cnt[0]; r0 = r_cnt[0];
        @(posedge clk); #1;
        araddr = 32'h1000_0040; arvalid = 1'b1;
        wait_cnt(0, 0, a0, "hold_accept");
        arvalid = 1'b0;
        cycles(3);
        chk("hold_csb_valid", 32'(csb_valid[0]), 32'd1);
        chk("hold_csb_addr", 32'(csb_addr[0]), 32'h0010);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_csb_valid", 32'(csb_valid[0]), 32'd0);
        chk("async_rst_csb_addr", 32'(csb_addr[0]), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        csb_ready = 1'b1;
        cycles(5);
        chk("async_rst_no_response", 32'(r_cnt[0] - r0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
